sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter sharing one async SRAM among NREQ requesters
module sram_arbiter #(
    parameter int NREQ    = 4,
    parameter int ACC_CYC = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ-1:0]       i_we,
    input  logic [NREQ-1:0][19:0] i_addr,
    input  logic [NREQ-1:0][15:0] i_wdata,
    output logic [NREQ-1:0]       o_gnt,
    output logic [NREQ-1:0]       o_ack,
    output logic [15:0]           o_rdata,
    output logic                  o_busy,
    output logic [19:0]           o_sram_addr,
    output logic                  o_sram_ce_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n,
    output logic                  o_sram_lb_n,
    output logic                  o_sram_ub_n,
    inout  wire  [15:0]           io_sram_dq
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            we_q, we_d;
    logic [19:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [15:0]     rdata_q, rdata_d;
    logic [IW-1:0]   win;
    logic            found;
    logic            last;
    logic            dq_oe;
    int              cand;

    assign last = (cnt_q == 4'(ACC_CYC - 1));

    // First requesting index at or above ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && i_req[cand[IW-1:0]]) begin
                found = 1'b1;
                win   = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    idx_d   = win;
                    we_d    = i_we[win];
                    addr_d  = i_addr[win];
                    wdata_d = i_wdata[win];
                    ptr_d   = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
            end
            ACCESS: begin
                if (last) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    ack_d[idx_q] = 1'b1;
                    if (!we_q) rdata_d = io_sram_dq;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from registers so reset forces them high at once.
    always_comb begin
        o_gnt       = '0;
        o_busy      = 1'b0;
        o_sram_addr = '0;
        o_sram_ce_n = 1'b1;
        o_sram_oe_n = 1'b1;
        o_sram_we_n = 1'b1;
        o_sram_lb_n = 1'b1;
        o_sram_ub_n = 1'b1;
        dq_oe       = 1'b0;
        if (state_q == ACCESS) begin
            o_busy      = 1'b1;
            o_sram_addr = addr_q;
            o_sram_ce_n = 1'b0;
            o_sram_lb_n = 1'b0;
            o_sram_ub_n = 1'b0;
            o_sram_oe_n = we_q;
            o_sram_we_n = !(we_q && !last);
            dq_oe       = we_q;
            if (cnt_q == 4'd0) o_gnt[idx_q] = 1'b1;
        end
    end

    assign o_ack      = ack_q;
    assign o_rdata    = rdata_q;
    assign io_sram_dq = dq_oe ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed and random checks of sram_arbiter against a transaction-level model
module tb_sram_arbiter;

    localparam int NREQ = 4;
    localparam int ACC  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        req = '0;
    logic [3:0]        we = '0;
    logic [3:0][19:0]  addr = '0;
    logic [3:0][15:0]  wdata = '0;
    logic [3:0]        gnt, ack;
    logic [15:0]       rdata;
    logic              busy;
    logic [19:0]       sram_addr;
    logic              ce_n, oe_n, we_n, lb_n, ub_n;
    wire  [15:0]       dq;

    logic [3:0]        req4 = '0;
    logic [3:0]        we4 = '0;
    logic [3:0][19:0]  addr4 = '0;
    logic [3:0][15:0]  wdata4 = '0;
    logic [3:0]        gnt4, ack4;
    logic [15:0]       rdata4;
    logic              busy4;
    logic [19:0]       sram_addr4;
    logic              ce4_n, oe4_n, we4_n, lb4_n, ub4_n;
    wire  [15:0]       dq4;

    always #5 clk = ~clk;

    sram_arbiter #(.NREQ(NREQ), .ACC_CYC(ACC)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_gnt(gnt), .o_ack(ack), .o_rdata(rdata), .o_busy(busy), .o_sram_addr(sram_addr),
        .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
        .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n), .io_sram_dq(dq)
    );

    sram_arbiter #(.NREQ(NREQ), .ACC_CYC(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_req(req4), .i_we(we4), .i_addr(addr4), .i_wdata(wdata4),
        .o_gnt(gnt4), .o_ack(ack4), .o_rdata(rdata4), .o_busy(busy4), .o_sram_addr(sram_addr4),
        .o_sram_ce_n(ce4_n), .o_sram_oe_n(oe4_n), .o_sram_we_n(we4_n),
        .o_sram_lb_n(lb4_n), .o_sram_ub_n(ub4_n), .io_sram_dq(dq4)
    );

    assign dq4 = (!ce4_n && !oe4_n) ? 16'hC0DE : 16'hzzzz;

    // Behavioural SRAM: 256 words, unwritten words read back a fixed pattern.
    logic [15:0]  sram_mem [256];
    logic [255:0] sram_vld = '0;
    logic [15:0]  sram_rd;

    function automatic logic [15:0] dflt(input logic [7:0] a);
        return {8'h00, a} ^ 16'h5A5A;
    endfunction

    always_comb sram_rd = sram_vld[sram_addr[7:0]] ? sram_mem[sram_addr[7:0]] : dflt(sram_addr[7:0]);
    assign dq = (!ce_n && !oe_n && we_n) ? sram_rd : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            sram_mem[sram_addr[7:0]] = dq;
            sram_vld[sram_addr[7:0]] = 1'b1;
        end
    end

    int tests = 0;
    int fails = 0;

    // Transaction-level reference: one outstanding access, grant/ack times by arithmetic.
    logic [15:0]  ref_mem [256];
    logic [255:0] ref_vld = '0;
    int           cyc, free_at, g_cyc, m_w, m_ptr;
    logic         m_we;
    logic [19:0]  m_addr;
    logic [15:0]  m_wdata, m_rd, exp_rdata;
    int           obs_g[$];
    int           obs_c[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_rd(input logic [7:0] a);
        return ref_vld[a] ? ref_mem[a] : dflt(a);
    endfunction

    task automatic model_reset();
        cyc = 0; free_at = 0; g_cyc = -100; m_w = 0; m_ptr = 0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rd = '0; exp_rdata = '0;
    endtask

    task automatic reset_dut();
        #2 rst = 1'b1;
        #1;
        chk("rst_gnt", gnt, 4'b0);
        chk("rst_ack", ack, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_addr", sram_addr, 20'h0);
        chk("rst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cycle();
        int  w;
        int  k;
        logic in_acc;
        if (cyc >= free_at && req != 4'b0) begin
            w = -1;
            for (int i = 0; i < NREQ; i++) begin
                k = (m_ptr + i) % NREQ;
                if (w < 0 && req[k]) w = k;
            end
            m_w = w; m_we = we[w]; m_addr = addr[w]; m_wdata = wdata[w];
            m_rd = ref_rd(addr[w][7:0]);
            g_cyc = cyc + 1; free_at = cyc + 1 + ACC; m_ptr = (w + 1) % NREQ;
        end
        @(posedge clk); #1;
        cyc++;
        in_acc = (cyc >= g_cyc) && (cyc < g_cyc + ACC);
        if (cyc == g_cyc + ACC) begin
            if (m_we) begin
                ref_mem[m_addr[7:0]] = m_wdata;
                ref_vld[m_addr[7:0]] = 1'b1;
            end else begin
                exp_rdata = m_rd;
            end
        end
        chk("gnt", gnt, (cyc == g_cyc) ? (4'b1 << m_w) : 4'b0);
        chk("ack", ack, (cyc == g_cyc + ACC) ? (4'b1 << m_w) : 4'b0);
        chk("busy", busy, in_acc);
        chk("strobes", {ce_n, oe_n, we_n, lb_n, ub_n},
            in_acc ? {1'b0, m_we, !(m_we && cyc < g_cyc + ACC - 1), 2'b00} : 5'b11111);
        if (in_acc) chk("sram_addr", sram_addr, m_addr);
        if (in_acc && m_we) chk("dq_write", dq, m_wdata);
        chk("rdata", rdata, exp_rdata);
        if (gnt != 4'b0) begin
            obs_g.push_back($clog2(gnt));
            obs_c.push_back(cyc);
        end
    endtask

    initial begin
        model_reset();
        reset_dut();

        // Put 0xBEEF at 0x00123 through the arbiter, then read it back on requester 1.
        req = 4'b0100; we[2] = 1'b1; addr[2] = 20'h00123; wdata[2] = 16'hBEEF;
        cycle(); req = 4'b0;
        repeat (ACC + 1) cycle();
        req = 4'b0010; we[1] = 1'b0; addr[1] = 20'h00123;
        cycle(); req = 4'b0;
        chk("rd_gnt_t1", gnt, 4'b0010);
        chk("rd_oe_t1", oe_n, 1'b0);
        cycle();
        chk("rd_oe_t2", oe_n, 1'b0);
        cycle();
        chk("rd_ack_t3", ack, 4'b0010);
        chk("rd_data_t3", rdata, 16'hBEEF);
        cycle();

        // Single write on requester 0.
        req = 4'b0001; we[0] = 1'b1; addr[0] = 20'h00010; wdata[0] = 16'h1234;
        cycle(); req = 4'b0;
        chk("wr_we_low", we_n, 1'b0);
        chk("wr_dq", dq, 16'h1234);
        cycle();
        chk("wr_we_hold", we_n, 1'b1);
        cycle();
        chk("wr_ack_t3", ack, 4'b0001);
        cycle();
        chk("wr_mem", sram_mem[8'h10], 16'h1234);

        // All four requesting from reset release.
        we = 4'b0; req = 4'b1111;
        reset_dut();
        obs_g.delete(); obs_c.delete();
        repeat (5 * (ACC + 1)) cycle();
        req = 4'b0;
        chk("rr_count", obs_g.size(), 5);
        if (obs_g.size() >= 5) begin
            chk("rr_first_cyc", obs_c[0], 1);
            for (int i = 0; i < 5; i++) chk("rr_order", obs_g[i], i % 4);
            for (int i = 0; i < 4; i++) chk("rr_spacing", obs_c[i + 1] - obs_c[i], ACC + 1);
        end
        repeat (ACC + 1) cycle();

        // Pointer at 3 when requesters 2 and 3 rise together.
        reset_dut();
        req = 4'b0100;
        cycle(); req = 4'b0;
        repeat (ACC + 1) cycle();
        obs_g.delete(); obs_c.delete();
        req = 4'b1100;
        repeat (2 * (ACC + 1)) cycle();
        req = 4'b0;
        chk("ptr3_count", obs_g.size(), 2);
        if (obs_g.size() >= 2) begin
            chk("ptr3_first", obs_g[0], 3);
            chk("ptr3_second", obs_g[1], 2);
        end
        repeat (ACC + 1) cycle();

        // Reset during the first cycle of a write.
        reset_dut();
        req = 4'b0001; we[0] = 1'b1; addr[0] = 20'h00003; wdata[0] = 16'hAAAA;
        cycle(); req = 4'b0;
        chk("abort_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
        chk("abort_busy", busy, 1'b0);
        chk("abort_gnt", gnt, 4'b0);
        @(posedge clk); #1;
        chk("abort_no_ack", ack, 4'b0);
        rst = 1'b0;
        model_reset();
        chk("abort_no_write", sram_vld[3], 1'b0);
        we = 4'b0; req = 4'b0011;
        cycle(); req = 4'b0;
        chk("abort_ptr0_gnt", gnt, 4'b0001);
        repeat (ACC + 1) cycle();
        req = 4'b0010;
        cycle(); req = 4'b0;
        chk("abort_gnt1", gnt, 4'b0010);
        repeat (ACC + 1) cycle();

        // Random traffic against the reference.
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                req[r]   = ($urandom_range(0, 99) < 40);
                we[r]    = $urandom_range(0, 1);
                addr[r]  = 20'($urandom_range(0, 15));
                wdata[r] = 16'($urandom);
            end
            cycle();
        end
        req = 4'b0;
        repeat (ACC + 2) cycle();

        // Four-cycle access variant.
        req4 = 4'b0001; we4 = 4'b0; addr4[0] = 20'h00005;
        @(posedge clk); #1;
        req4 = 4'b0;
        for (int i = 0; i < 4; i++) begin
            chk("acc4_busy", busy4, 1'b1);
            chk("acc4_strobes", {ce4_n, oe4_n, we4_n, lb4_n, ub4_n}, 5'b00100);
            chk("acc4_gnt", gnt4, (i == 0) ? 4'b0001 : 4'b0000);
            chk("acc4_no_ack", ack4, 4'b0);
            @(posedge clk); #1;
        end
        chk("acc4_ack_t5", ack4, 4'b0001);
        chk("acc4_rdata", rdata4, 16'hC0DE);
        chk("acc4_idle", {busy4, ce4_n}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
